// File: rtl/shift_rx.sv
// shift_rx: LSB-first serial-to-parallel receiver with Valid/Ack handoff and sticky overrun flag
//   Clock   : single clock, all state changes on posedge
//   Reset   : asynchronous active-high, clears all state
//   Start   : begin/restart a frame (ignored in FULL unless Ack is also high)
//   E, w    : bit strobe and serial data bit (LSB first)
//   Ack     : consumer has taken Q (only acts while Valid)
//   Q       : last completed word, changes only on frame completion
//   Valid   : Q holds an untaken word (state FULL)
//   Busy    : a frame is in progress (state SHIFT)
//   Overrun : sticky, set by a strobe arriving while Valid
module shift_rx #(
    parameter int N = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Start,
    input  logic         E,
    input  logic         w,
    input  logic         Ack,
    output logic [N-1:0] Q,
    output logic         Valid,
    output logic         Busy,
    output logic         Overrun
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

    state_t        state, state_nx;
    logic [N-1:0]  s, s_nx, q_nx, s_in;
    logic [CW-1:0] c, c_nx;
    logic          ovr_nx;

    assign s_in  = {w, s[N-1:1]};
    assign Busy  = state == SHIFT;
    assign Valid = state == FULL;

    always_ff @(posedge Clock or posedge Reset)
        if (Reset) begin
            state   <= IDLE;
            s       <= '0;
            c       <= '0;
            Q       <= '0;
            Overrun <= 1'b0;
        end else begin
            state   <= state_nx;
            s       <= s_nx;
            c       <= c_nx;
            Q       <= q_nx;
            Overrun <= ovr_nx;
        end

    always_comb begin
        state_nx = state;
        s_nx     = s;
        c_nx     = c;
        q_nx     = Q;
        ovr_nx   = Overrun;
        case (state)
            IDLE: if (Start) begin
                state_nx = SHIFT;
                c_nx     = '0;
            end
            SHIFT: if (Start) c_nx = '0;
            else if (E) begin
                s_nx = s_in;
                // last bit lands directly in Q so completion and Valid coincide
                if (c == CW'(N - 1)) begin
                    q_nx     = s_in;
                    c_nx     = '0;
                    state_nx = FULL;
                end else c_nx = c + 1'b1;
            end
            FULL: begin
                ovr_nx = Overrun | E;
                if (Ack) begin
                    state_nx = Start ? SHIFT : IDLE;
                    c_nx     = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule
